divide_xn_prog: RTL and testbench
=================================

DIVIDE_XN_PROG -- requirements
Module: divide_xn_prog

Interface
REQ-001 Parameter W, default 8, counter/divisor width in bits (W >= 2).
REQ-002 Parameter DEFAULT_DIV, default 10, divisor after reset (2 <= DEFAULT_DIV <= 2^W-1).
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 CLEAR  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  count enable; 0 = freeze.
REQ-006 LOAD  input  1  single-cycle request to apply DIV, DUTY and MODE.
REQ-007 DIV  input  W  requested divisor.
REQ-008 DUTY  input  W  requested high-time in counts for square mode.
REQ-009 MODE  input  1  requested mode: 0 = pulse, 1 = duty/square.
REQ-010 COUNT  output  W  current count, registered.
REQ-011 OUT  output  1  divided output, registered.
REQ-012 TICK  output  1  terminal-count strobe.
REQ-013 LOAD_ACK  output  1  one-cycle strobe: new settings took effect.

Function
REQ-014 Active settings SHALL be held in internal registers div_q, duty_q and mode_q, separate from the input ports.
REQ-015 Clamp rules, applied when settings are captured:
- DIV of 0 or 1 -> div_q = 2.
- DUTY of 0 -> duty_q = 1.
- DUTY >= effective divisor -> duty_q = effective divisor - 1.
REQ-016 With EN=1, COUNT SHALL step 0,1,...,div_q-1, then wrap to 0; period is exactly div_q cycles.
REQ-017 With EN=0, COUNT, OUT and all settings SHALL hold, except as REQ-022 allows; TICK = 0.
REQ-018 TICK SHALL be 1 exactly in cycles where EN=1 and COUNT == div_q-1.
REQ-019 OUT SHALL be registered but consistent with COUNT in the same cycle:
- mode_q=0: OUT = (COUNT == div_q-1).
- mode_q=1: OUT = (COUNT < duty_q).
REQ-020 LOAD=1 SHALL capture DIV/DUTY/MODE into a staging register and set pending.
- A further LOAD while pending SHALL overwrite the staged values; the last LOAD wins.
REQ-021 Apply point with EN=1: the wrap edge (COUNT == div_q-1).
- Staged values, or the LOAD inputs if LOAD=1 in that same cycle, SHALL be copied into the active registers.
- pending SHALL clear.
- The next period SHALL use the new settings from COUNT=0.
REQ-022 Apply point with EN=0 and pending, or with LOAD=1: the next edge.
- Settings SHALL be applied.
- COUNT SHALL be forced to 0.
- OUT SHALL be recomputed per REQ-019 under the new settings.
REQ-023 LOAD_ACK SHALL be 1 for exactly one cycle, the cycle after each apply edge; it SHALL fire once per application, regardless of how many LOADs were merged.
REQ-024 A mid-period LOAD SHALL NOT shorten or lengthen the current period.
REQ-025 Changing MODE alone through LOAD SHALL follow the same apply rules; OUT SHALL never glitch within a cycle.

Reset
REQ-026 CLEAR=1 at an edge SHALL set:
- COUNT=0, OUT=0, LOAD_ACK=0, pending=0.
- div_q=DEFAULT_DIV, duty_q=DEFAULT_DIV/2 (integer), mode_q=0.
REQ-027 CLEAR SHALL take priority over LOAD and EN.
- A pending or simultaneous LOAD is discarded; no LOAD_ACK follows.
REQ-028 After reset TICK SHALL read 0 (COUNT=0 != div_q-1).

Verification
REQ-029 Default run: reset, EN=1 for 40 cycles -> COUNT 0..9 repeating; TICK and OUT high only at COUNT=9, every 10th cycle.
REQ-030 Mid-period load:
- Stimulus: LOAD with DIV=4, DUTY=1, MODE=1 at COUNT=3.
- Response: COUNT continues to 9; LOAD_ACK high one cycle after the wrap; then period 4 with OUT high only at COUNT=0 (1 of 4).
REQ-031 Clamping:
- DIV=0 and DIV=1 -> period 2.
- DIV=5, DUTY=7, MODE=1 -> OUT high for COUNT 0..3, low at 4.
- DUTY=0 -> OUT high only at COUNT 0.
REQ-032 Enable gating:
- EN=0 at COUNT=5 for 3 cycles -> COUNT stays 5, TICK=0, OUT unchanged.
- On resume, COUNT reaches 9 after 4 more enabled cycles.
- LOAD DIV=3 while EN=0 -> COUNT=0 next edge and LOAD_ACK one cycle later.
REQ-033 Merged loads: LOAD DIV=6 at COUNT=2, LOAD DIV=7 at COUNT=4, period 10 -> exactly one LOAD_ACK after the wrap; the next period is 7.
REQ-034 Reset mid-operation:
- Stimulus: CLEAR=1 at COUNT=7 with a load pending (DIV=3).
- Response: reset values per REQ-026; with EN=1 the period is 10; no LOAD_ACK is ever produced for the discarded load.

Source files
------------

// File: rtl/divide_xn_prog.sv
// Programmable clock divider with pulse or square output.
// New settings are staged on load and applied at the period wrap, or immediately while counting is frozen.
module divide_xn_prog #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] div,
    input  logic [W-1:0] duty,
    input  logic         mode,
    output logic [W-1:0] count,
    output logic         out,
    output logic         tick,
    output logic         load_ack
);

    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] TWO      = W'(2);
    localparam logic [W-1:0] DEF_DIV  = W'(DEFAULT_DIV);
    localparam logic [W-1:0] DEF_DUTY = W'(DEFAULT_DIV / 2);

    logic [W-1:0] div_q;
    logic [W-1:0] duty_q;
    logic         mode_q;
    logic         pending;
    logic [W-1:0] stage_div;
    logic [W-1:0] stage_duty;
    logic         stage_mode;

    logic         at_wrap;
    logic         apply;
    logic [W-1:0] src_div;
    logic [W-1:0] src_duty;
    logic         src_mode;
    logic [W-1:0] new_div;
    logic [W-1:0] new_duty;

    logic [W-1:0] count_d;
    logic [W-1:0] div_d;
    logic [W-1:0] duty_d;
    logic         mode_d;
    logic         out_d;
    logic         pending_d;
    logic         stage_we;

    assign at_wrap = (count == div_q - ONE);
    assign tick    = en && at_wrap;

    // A load in the apply cycle itself bypasses the staging registers.
    always_comb begin
        src_div  = stage_div;
        src_duty = stage_duty;
        src_mode = stage_mode;
        if (load) begin
            src_div  = div;
            src_duty = duty;
            src_mode = mode;
        end
        new_div = (src_div < TWO) ? TWO : src_div;
        if (src_duty == '0) begin
            new_duty = ONE;
        end else if (src_duty >= new_div) begin
            new_duty = new_div - ONE;
        end else begin
            new_duty = src_duty;
        end
    end

    // Running: only the wrap edge may apply, so the current period is never disturbed.
    always_comb begin
        if (en) begin
            apply = at_wrap && (pending || load);
        end else begin
            apply = pending || load;
        end
    end

    always_comb begin
        count_d   = count;
        div_d     = div_q;
        duty_d    = duty_q;
        mode_d    = mode_q;
        pending_d = pending;
        stage_we  = load && !apply;
        if (apply) begin
            count_d   = '0;
            div_d     = new_div;
            duty_d    = new_duty;
            mode_d    = src_mode;
            pending_d = 1'b0;
        end else begin
            if (en) begin
                count_d = at_wrap ? '0 : count + ONE;
            end
            if (load) begin
                pending_d = 1'b1;
            end
        end
        // Output is derived from next-state values so it matches count in the same cycle.
        if (mode_d) begin
            out_d = (count_d < duty_d);
        end else begin
            out_d = (count_d == div_d - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count      <= '0;
            out        <= 1'b0;
            load_ack   <= 1'b0;
            pending    <= 1'b0;
            div_q      <= DEF_DIV;
            duty_q     <= DEF_DUTY;
            mode_q     <= 1'b0;
            stage_div  <= DEF_DIV;
            stage_duty <= DEF_DUTY;
            stage_mode <= 1'b0;
        end else begin
            count    <= count_d;
            out      <= out_d;
            load_ack <= apply;
            pending  <= pending_d;
            div_q    <= div_d;
            duty_q   <= duty_d;
            mode_q   <= mode_d;
            if (stage_we) begin
                stage_div  <= div;
                stage_duty <= duty;
                stage_mode <= mode;
            end
        end
    end

endmodule

// File: tb/tb_divide_xn_prog.sv
// Scoreboard bench for divide_xn_prog: a behavioural model queues the expected post-edge outputs
// and a monitor compares them; each scenario task also checks its headline behaviour directly.
module tb_divide_xn_prog;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clear = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] div = '0;
    logic [W-1:0] duty = '0;
    logic         mode = 1'b0;
    logic [W-1:0] count;
    logic         out;
    logic         tick;
    logic         load_ack;

    typedef struct {
        int count;
        bit out;
        bit tick;
        bit ack;
    } exp_t;

    exp_t q[$];
    exp_t monX;
    int   checks = 0;
    int   failures = 0;

    int mc = 0, mdiv = 10, mduty = 5, sdiv = 10, sduty = 5;
    bit mmode = 0, smode = 0, mpend = 0;

    divide_xn_prog #(.W(W), .DEFAULT_DIV(10)) dut (
        .clk(clk), .clear(clear), .en(en), .load(load), .div(div), .duty(duty),
        .mode(mode), .count(count), .out(out), .tick(tick), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drives one cycle of stimulus and queues what the outputs must show after the edge.
    task automatic applyStimulus(input bit e, input bit l, input bit clr,
                                 input int d, input int u, input bit m);
        exp_t x;
        bit   ap;
        en = e; load = l; clear = clr; div = d[W-1:0]; duty = u[W-1:0]; mode = m;
        ap = 0;
        if (clr) begin
            mc = 0; mdiv = 10; mduty = 5; mmode = 0; mpend = 0;
            sdiv = 10; sduty = 5; smode = 0;
        end else begin
            if (e && mc == mdiv - 1) begin
                ap = l || mpend;
                mc = 0;
            end else if (e) begin
                mc = mc + 1;
                if (l) begin
                    sdiv = d; sduty = u; smode = m; mpend = 1;
                end
            end else if (l || mpend) begin
                ap = 1;
                mc = 0;
            end
            if (ap) begin
                if (l) begin
                    sdiv = d; sduty = u; smode = m;
                end
                mdiv  = (sdiv < 2) ? 2 : sdiv;
                mduty = (sduty == 0) ? 1 : ((sduty >= mdiv) ? mdiv - 1 : sduty);
                mmode = smode;
                mpend = 0;
            end
        end
        x.count = mc;
        x.out   = mmode ? (mc < mduty) : (mc == mdiv - 1);
        x.tick  = e && (mc == mdiv - 1);
        x.ack   = ap;
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) applyStimulus(e, 0, 0, 0, 0, 0);
    endtask

    // Scoreboard monitor samples 1 time unit after each edge, before the next stimulus.
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            monX = q.pop_front();
            checks += 4;
            if (count !== monX.count[W-1:0]) begin
                failures++;
                $display("[TB] FAIL sb_count t=%0t got=%0d exp=%0d", $time, count, monX.count);
            end
            if (out !== monX.out) begin
                failures++;
                $display("[TB] FAIL sb_out t=%0t got=%b exp=%b", $time, out, monX.out);
            end
            if (tick !== monX.tick) begin
                failures++;
                $display("[TB] FAIL sb_tick t=%0t got=%b exp=%b", $time, tick, monX.tick);
            end
            if (load_ack !== monX.ack) begin
                failures++;
                $display("[TB] FAIL sb_ack t=%0t got=%b exp=%b", $time, load_ack, monX.ack);
            end
        end
    end

    task automatic test_reset();
        applyStimulus(1, 1, 1, 3, 1, 1);
        checks++;
        if (count !== 8'd0 || out !== 1'b0 || tick !== 1'b0 || load_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state got count=%0d out=%b tick=%b ack=%b exp 0/0/0/0",
                     count, out, tick, load_ack);
        end
        applyStimulus(1, 0, 0, 0, 0, 0);
        checks++;
        if (count !== 8'd1 || load_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_discard got count=%0d ack=%b exp 1/0", count, load_ack);
        end
    endtask

    task automatic test_default_run();
        int ticks = 0, highs = 0;
        applyStimulus(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            if (tick === 1'b1) ticks++;
            if (out === 1'b1) highs++;
        end
        checks++;
        if (ticks != 4 || highs != 4 || count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL default_run got ticks=%0d highs=%0d count=%0d exp 4/4/0",
                     ticks, highs, count);
        end
    endtask

    task automatic test_mid_load();
        int n = 0, highs = 0;
        applyStimulus(0, 0, 1, 0, 0, 0);
        run(3, 1);
        applyStimulus(1, 1, 0, 4, 1, 1);
        while (n < 20) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            n++;
            if (load_ack === 1'b1) break;
        end
        checks++;
        if (n != 6 || count !== 8'd0 || out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_load_ack got cycles=%0d count=%0d out=%b exp 6/0/1", n, count, out);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            if (out === 1'b1) highs++;
        end
        checks++;
        if (highs != 2) begin
            failures++;
            $display("[TB] FAIL mid_load_duty got highs=%0d exp 2", highs);
        end
    endtask

    task automatic test_clamp();
        int ticks;
        logic [4:0] pat;
        for (int dv = 0; dv < 2; dv++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
            applyStimulus(0, 1, 0, dv, 3, 0);
            ticks = 0;
            for (int i = 0; i < 6; i++) begin
                applyStimulus(1, 0, 0, 0, 0, 0);
                if (tick === 1'b1) ticks++;
            end
            checks++;
            if (ticks != 3) begin
                failures++;
                $display("[TB] FAIL clamp_div%0d got ticks=%0d exp 3", dv, ticks);
            end
        end
        applyStimulus(0, 1, 0, 5, 7, 1);
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            pat[i] = out;
        end
        checks++;
        if (pat !== 5'b10111) begin
            failures++;
            $display("[TB] FAIL clamp_duty_high got=%b exp=10111", pat);
        end
        applyStimulus(0, 1, 0, 5, 0, 1);
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            pat[i] = out;
        end
        checks++;
        if (pat !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL clamp_duty_zero got=%b exp=10000", pat);
        end
    endtask

    task automatic test_enable_gating();
        applyStimulus(0, 0, 1, 0, 0, 0);
        run(5, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checks++;
            if (count !== 8'd5 || tick !== 1'b0 || out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL gate_hold got count=%0d tick=%b out=%b exp 5/0/0", count, tick, out);
            end
        end
        run(4, 1);
        checks++;
        if (count !== 8'd9 || tick !== 1'b1) begin
            failures++;
            $display("[TB] FAIL gate_resume got count=%0d tick=%b exp 9/1", count, tick);
        end
        applyStimulus(0, 1, 0, 3, 1, 0);
        checks++;
        if (count !== 8'd0 || load_ack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL gate_load got count=%0d ack=%b exp 0/1", count, load_ack);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checks++;
        if (load_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gate_ack_once got ack=%b exp 0", load_ack);
        end
    endtask

    task automatic test_merged_loads();
        int acks = 0;
        applyStimulus(0, 0, 1, 0, 0, 0);
        run(2, 1);
        applyStimulus(1, 1, 0, 6, 1, 0);
        run(1, 1);
        applyStimulus(1, 1, 0, 7, 1, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            if (load_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 1 || count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL merged got acks=%0d count=%0d exp 1/0", acks, count);
        end
    endtask

    task automatic test_clear_pending();
        int acks = 0, ticks = 0;
        applyStimulus(0, 0, 1, 0, 0, 0);
        run(3, 1);
        applyStimulus(1, 1, 0, 3, 1, 0);
        run(3, 1);
        applyStimulus(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            if (load_ack === 1'b1) acks++;
            if (tick === 1'b1) ticks++;
        end
        checks++;
        if (acks != 0 || ticks != 2) begin
            failures++;
            $display("[TB] FAIL clear_pending got acks=%0d ticks=%0d exp 0/2", acks, ticks);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 60) == 0, $urandom_range(0, 12),
                          $urandom_range(0, 14), $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_mid_load();
        test_clamp();
        test_enable_gating();
        test_merged_loads();
        test_clear_pending();
        test_back_to_back();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
